// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns single-cycle lw/sw strobes into a req/ack bus transaction, stalling the datapath meanwhile.
// Optional misalignment rejection is compiled in with `define DMEM_ALIGN_CHECK_EN.
module dmem_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter value seen in the last BUS cycle before giving up.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state_reg;
  logic [7:0] cnt_reg;
  logic       req;
  logic       misaligned;

  assign req = cpu_rd | cpu_wr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (cpu_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];
  assign misaligned      = 1'b0;
`endif

  assign stall = ((state_reg == IDLE) && req) || (state_reg == BUS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'd0;
      mem_wdata <= 32'd0;
      cpu_rdata <= 32'd0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            // Conflicting strobes resolve to a write but are still flagged.
            if (cpu_rd && cpu_wr) err <= 1'b1;
            if (misaligned) begin
              err       <= 1'b1;
              if (!cpu_wr) cpu_rdata <= ERR_DATA;
              state_reg <= DONE;
            end else begin
              mem_we    <= cpu_wr;
              mem_addr  <= cpu_addr[31:2];
              mem_wdata <= cpu_wdata;
              cnt_reg   <= 8'd0;
              mem_req   <= 1'b1;
              state_reg <= BUS;
            end
          end
        end
        BUS: begin
          // Ack takes priority over an expiring timeout.
          if (mem_ack) begin
            if (!mem_we) cpu_rdata <= mem_rdata;
            mem_req   <= 1'b0;
            state_reg <= DONE;
          end else if (cnt_reg == TO_LAST) begin
            mem_req   <= 1'b0;
            cpu_rdata <= ERR_DATA;
            err       <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge (TIMEOUT=8); honours DMEM_ALIGN_CHECK_EN if defined.
module tb_dmem_bridge;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        stall, err, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int          st, rq;
  logic [31:0] rdo;
  logic        we, ws;
  logic [29:0] ad;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 in IDLE; returns at posedge+1 after the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_after, input logic [31:0] rdata,
                        output int stalls, output int reqs, output logic [31:0] rdout,
                        output logic we_seen, output logic [29:0] addr_seen, output logic wstable);
    bit done;
    done = 0; stalls = 0; reqs = 0; rdout = '0; we_seen = 0; addr_seen = '0; wstable = 1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done  = 1;
        rdout = cpu_rdata;
        check("req_low_in_done", {31'd0, mem_req}, 32'd0);
      end else begin
        stalls++;
        if (mem_req) begin
          reqs++;
          we_seen   = mem_we;
          addr_seen = mem_addr;
          if (mem_wdata !== wdata) wstable = 0;
          if (reqs == ack_after) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
          end
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end
    if (!done) check("access_bound", 32'd0, 32'd1);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_state_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {2'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    $display("reset checked");

    // lw 0x10, ack in first BUS cycle
    access(1, 0, 32'h0000_0010, 32'd0, 1, 32'h1234_5678, st, rq, rdo, we, ad, ws);
    check("lw_addr", {2'd0, ad}, 32'h4);
    check("lw_we", {31'd0, we}, 32'd0);
    check("lw_stalls", st, 2);
    check("lw_rdata", rdo, 32'h1234_5678);
    check("lw_err", {31'd0, err}, 32'd0);
    $display("lw 0x10: stalls=%0d rdata=%h", st, rdo);

    // sw 0xCAFEF00D to 0x100, ack after 4 BUS cycles
    access(0, 1, 32'h0000_0100, 32'hCAFE_F00D, 4, 32'h0, st, rq, rdo, we, ad, ws);
    check("sw_we", {31'd0, we}, 32'd1);
    check("sw_addr", {2'd0, ad}, 32'h40);
    check("sw_wdata_stable", {31'd0, ws}, 32'd1);
    check("sw_stalls", st, 5);
    check("sw_req_cycles", rq, 4);
    check("sw_rdata_kept", rdo, 32'h1234_5678);
    $display("sw 0x100: stalls=%0d req_cycles=%0d", st, rq);

    // Ack in the same cycle the timeout would fire: normal completion
    access(1, 0, 32'h0000_0020, 32'd0, TO, 32'h0BAD_F00D, st, rq, rdo, we, ad, ws);
    check("race_rdata", rdo, 32'h0BAD_F00D);
    check("race_err", {31'd0, err}, 32'd0);
    check("race_stalls", st, TO + 1);
    $display("ack at timeout: stalls=%0d rdata=%h", st, rdo);

    // Spurious ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("spur_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0; mem_rdata = '0;
    check("spur_req", {31'd0, mem_req}, 32'd0);
    check("spur_rdata", cpu_rdata, 32'h0BAD_F00D);
    access(1, 0, 32'h0000_0030, 32'd0, 1, 32'h7777_0001, st, rq, rdo, we, ad, ws);
    check("post_spur_stalls", st, 2);
    check("post_spur_rdata", rdo, 32'h7777_0001);
    $display("spurious ack: follow-up stalls=%0d", st);

    // Asynchronous reset mid-BUS
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    check("midbus_req_high", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_req_drop", {31'd0, mem_req}, 32'd0);
    cpu_rd = 1'b0; cpu_addr = '0;
    #1;
    check("async_stall", {31'd0, stall}, 32'd0);
    check("async_rdata", cpu_rdata, 32'd0);
    check("async_addr", {2'd0, mem_addr}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("async reset mid-BUS checked");

    // rd & wr together: write issued, err set
    access(1, 1, 32'h0000_0200, 32'h0F0F_0F0F, 1, 32'h5555_5555, st, rq, rdo, we, ad, ws);
    check("both_we", {31'd0, we}, 32'd1);
    check("both_addr", {2'd0, ad}, 32'h80);
    check("both_err", {31'd0, err}, 32'd1);
    check("both_rdata_kept", rdo, 32'd0);
    $display("rd&wr: we=%0d err=%0d", we, err);
    apply_reset();

    // Unaligned lw 0x102
    access(1, 0, 32'h0000_0102, 32'd0, 1, 32'hA5A5_5A5A, st, rq, rdo, we, ad, ws);
`ifdef DMEM_ALIGN_CHECK_EN
    check("unal_stalls", st, 1);
    check("unal_reqs", rq, 0);
    check("unal_rdata", rdo, 32'hDEAD_BEEF);
    check("unal_err", {31'd0, err}, 32'd1);
`else
    check("unal_stalls", st, 2);
    check("unal_addr", {2'd0, ad}, 32'h40);
    check("unal_rdata", rdo, 32'hA5A5_5A5A);
    check("unal_err", {31'd0, err}, 32'd0);
`endif
    $display("lw 0x102: stalls=%0d rdata=%h err=%0d", st, rdo, err);
    apply_reset();

    // Timeout: no ack
    access(1, 0, 32'h0000_0300, 32'd0, 0, 32'd0, st, rq, rdo, we, ad, ws);
    check("to_req_cycles", rq, TO);
    check("to_stalls", st, TO + 1);
    check("to_rdata", rdo, 32'hDEAD_BEEF);
    check("to_err", {31'd0, err}, 32'd1);
    $display("timeout: req_cycles=%0d rdata=%h", rq, rdo);

    // err stays sticky across a good access
    access(1, 0, 32'h0000_0010, 32'd0, 2, 32'h2468_ACE0, st, rq, rdo, we, ad, ws);
    check("sticky_rdata", rdo, 32'h2468_ACE0);
    check("sticky_stalls", st, 3);
    check("sticky_err", {31'd0, err}, 32'd1);
    $display("good access after timeout: err=%0d", err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Handshaked data-memory bridge between the single-cycle datapath and a multi-cycle memory bus. It consumes the datapath's data-memory access (address, write data, `lw`/`sw` strobes) and converts it into a req/ack bus transaction. While the transaction is in flight it asserts `stall`, which freezes the PC and suppresses register/memory writes. It returns read data registered for the write-back mux and flags bus timeouts and illegal requests.

## Interface
Parameters:
- `TIMEOUT`, 255, max cycles in BUS waiting for `mem_ack` before abort (1..255, 8-bit counter)
- `ERR_DATA`, 32'hDEAD_BEEF, value returned on `cpu_rdata` for aborted/rejected reads

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_rd`  in  1  load request (`lw` decode)
- `cpu_wr`  in  1  store request (`writeMem`)
- `cpu_addr`  in  32  byte address from ALU/shift mux
- `cpu_wdata`  in  32  store data (rt value)
- `cpu_rdata`  out  32  load data, valid in DONE
- `stall`  out  1  datapath hold, combinational
- `err`  out  1  sticky error flag
- `mem_req`  out  1  bus request, registered
- `mem_we`  out  1  1 = write transaction
- `mem_addr`  out  30  word address (`cpu_addr[31:2]`)
- `mem_wdata`  out  32  write data
- `mem_ack`  in  1  bus completion, single-cycle pulse
- `mem_rdata`  in  32  read data, valid with `mem_ack`

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - `cpu_rd|cpu_wr` = 1 → latch addr/wdata/we, go BUS.
  - `stall` = 1 in this cycle.
- BUS:
  - `mem_req` = 1; `mem_we`/`mem_addr`/`mem_wdata` held stable from the latch.
  - `stall` = 1.
  - On `mem_ack`: capture `mem_rdata` if read (write leaves `cpu_rdata` unchanged), go DONE.
- DONE:
  - `stall` = 0; the datapath completes the instruction at this cycle's edge.
  - Always returns to IDLE; any request seen in DONE belongs to the finishing instruction and is ignored.
- `stall` = (IDLE & (`cpu_rd`|`cpu_wr`)) | BUS.
- Simultaneous `cpu_rd` & `cpu_wr`: executed as a write; `err` set.
- Timeout:
  - 8-bit counter cleared on BUS entry, incremented each BUS cycle without ack.
  - Reaching `TIMEOUT` → drop `mem_req`, `cpu_rdata` = `ERR_DATA`, set `err`, go DONE.
  - Ack arriving in the same cycle as timeout wins: normal completion, no error.
- `mem_ack` in IDLE or DONE: ignored; no state change.
- `err` is sticky; cleared only by reset.

## Timing
- Reset values: state IDLE; `mem_req` 0; `mem_we` 0; `mem_addr` 0; `mem_wdata` 0; `cpu_rdata` 0; `err` 0; counter 0. `stall` follows its equation, so it is 0 when no request is present.
- Reset is asynchronous, including mid-BUS: `mem_req` falls without waiting for a clock edge; the in-flight transaction is abandoned.
- Minimum access is 3 cycles:
  - IDLE cycle (request seen).
  - BUS cycle with ack.
  - DONE cycle.
  - Gives 2 stall cycles per `lw`/`sw`.
- An ack after N BUS cycles gives N+1 stall cycles.
- `mem_req` rises on the edge leaving IDLE and falls on the edge after `mem_ack` is sampled.
- Non-memory instructions: 0 stall cycles.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - Request in IDLE with `cpu_addr[1:0]` ≠ 0 issues no bus transaction.
  - FSM goes IDLE→DONE directly (1 stall cycle), sets `err`.
  - Reads return `ERR_DATA`; writes are dropped.
- Not defined: `cpu_addr[1:0]` is ignored; all accesses use `cpu_addr[31:2]`; no alignment error exists.

## Test plan
- Reset, then hold `rst`=0 mid-BUS → all outputs at reset values; `mem_req` drops asynchronously before the next clock edge.
- `lw` to 0x0000_0010, ack in the first BUS cycle with `mem_rdata`=0x1234_5678:
  - `mem_addr`=0x4.
  - `stall` high for 2 cycles.
  - `cpu_rdata`=0x1234_5678 in DONE.
  - `err`=0.
- `sw` of 0xCAFE_F00D to 0x100, ack delayed 4 cycles:
  - `mem_we`=1, `mem_addr`=0x40.
  - `mem_wdata` stable throughout BUS.
  - `stall` high for 5 cycles.
- `lw` with no ack and `TIMEOUT`=8:
  - `mem_req` high for 8 cycles, then drops.
  - `cpu_rdata`=0xDEAD_BEEF.
  - `err`=1 and stays set across later good accesses.
- `cpu_rd`=`cpu_wr`=1 → write transaction issued, `err`=1. Spurious `mem_ack` in IDLE → no state change.
- With `DMEM_ALIGN_CHECK_EN`: `lw` to 0x102 → no `mem_req`, 1 stall cycle, `cpu_rdata`=0xDEAD_BEEF, `err`=1. Without it: same access reads word 0x40.
